// File: rtl/signed_calc_ctrl.sv
// signed_calc_ctrl: sequences A then B through a shared two's complement converter, then adds and returns the result in sign-magnitude form
module signed_calc_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       a_mag,
  input  logic             a_sign,
  input  logic [3:0]       b_mag,
  input  logic             b_sign,
  input  logic             op,
  output logic [3:0]       tc_a,
  output logic             tc_en,
  input  logic [5:0]       tc_s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       res_mag,
  output logic             res_sign,
  output logic [CNT_W-1:0] op_count
);
  typedef enum logic [2:0] {IDLE, CONV_A, CONV_B, ADD, DONE} state_t;
  state_t state, state_nx;
  logic [3:0] am, bm;
  logic as, bs;
  logic [5:0] ra, rb, sum;
  logic [4:0] mag;
  assign sum = ra + rb;
  // the sum spans -30..+30, so the five low bits of the negation always hold the magnitude
  assign mag = sum[5] ? 5'(-sum) : sum[4:0];
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = in_valid ? CONV_A : IDLE;
      CONV_A:  state_nx = CONV_B;
      CONV_B:  state_nx = ADD;
      ADD:     state_nx = DONE;
      DONE:    state_nx = out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    in_ready  = state == IDLE;
    out_valid = state == DONE;
    tc_a      = state == CONV_A ? am : state == CONV_B ? bm : 4'd0;
    tc_en     = state == CONV_A ? as : state == CONV_B ? bs : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      am       <= '0;
      bm       <= '0;
      as       <= 1'b0;
      bs       <= 1'b0;
      ra       <= '0;
      rb       <= '0;
      res_mag  <= '0;
      res_sign <= 1'b0;
      op_count <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && in_valid) begin
        am <= a_mag;
        as <= a_sign;
        bm <= b_mag;
        bs <= b_sign ^ op;
      end
      if (state == CONV_A) ra <= tc_s;
      if (state == CONV_B) rb <= tc_s;
      if (state == ADD) begin
        res_sign <= sum[5];
        res_mag  <= mag;
      end
      if (state == DONE && out_ready) op_count <= op_count + CNT_W'(1);
    end
  end
endmodule
